// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the team FIFO: issues rd_en, absorbs the 1-cycle read latency and
// re-presents words as a valid/ready stream through a small circular output buffer.
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_valid_in,
    input  logic [$clog2(DEPTH):0]     fifo_occupancy_in,
    output logic                       fifo_rd_en_out,
    input  logic                       flush_in,
    output logic [WIDTH-1:0]           m_data_out,
    output logic                       m_valid_out,
    input  logic                       m_ready_in,
    output logic [CNT_WIDTH-1:0]       words_out,
    output logic                       err_out
);

    localparam int unsigned OCC_W     = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned BCNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W     = BCNT_W + 1;

    logic [WIDTH-1:0]  mem [BUF_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [BCNT_W-1:0] count;
    logic              inflight;

    logic              pop;
    logic              pop_eff;
    logic              capture_req;
    logic              capture;
    logic              overflow;
    logic [SUM_W-1:0]  pending;
    logic [PTR_W-1:0]  head_nxt;
    logic [PTR_W-1:0]  tail_nxt;

    // Handshake, read issue and buffer update decisions for this cycle
    always_comb begin
        m_valid_out    = 1'b0;
        pop            = 1'b0;
        pop_eff        = 1'b0;
        pending        = '0;
        fifo_rd_en_out = 1'b0;
        capture_req    = 1'b0;
        overflow       = 1'b0;
        capture        = 1'b0;
        head_nxt       = '0;
        tail_nxt       = '0;

        m_valid_out = !rst_in && (count != '0);
        pop         = m_valid_out && m_ready_in;
        pop_eff     = pop && !flush_in;

        // Counting this cycle's pop lets a 2-entry buffer keep one word per cycle flowing
        pending        = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
        fifo_rd_en_out = !rst_in && !flush_in && (fifo_occupancy_in != OCC_W'(0))
                         && (pending < SUM_W'(BUF_DEPTH));

        capture_req = fifo_valid_in && inflight;
        overflow    = capture_req && !flush_in && !pop_eff
                      && (count == BCNT_W'(BUF_DEPTH));
        capture     = capture_req && !flush_in && !overflow;

        head_nxt = (head == PTR_W'(BUF_DEPTH - 1)) ? '0 : head + PTR_W'(1);
        tail_nxt = (tail == PTR_W'(BUF_DEPTH - 1)) ? '0 : tail + PTR_W'(1);
    end

    assign m_data_out = mem[head];

    // Buffer, in-flight tracking, delivered-word counter and sticky error
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            words_out <= '0;
            err_out   <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_rd_en_out;

            if ((fifo_valid_in != inflight) || overflow) begin
                err_out <= 1'b1;
            end

            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (capture) begin
                    mem[tail] <= fifo_data_in;
                    tail      <= tail_nxt;
                end
                if (pop_eff) begin
                    head      <= head_nxt;
                    words_out <= words_out + CNT_WIDTH'(1);
                end
                case ({capture, pop_eff})
                    2'b10:   count <= count + BCNT_W'(1);
                    2'b01:   count <= count - BCNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader; a behavioural FIFO plus an in-order
// scoreboard of words handed out by the FIFO predict what must appear downstream.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned OCC_W     = $clog2(DEPTH) + 1;

    logic                 clk_in;
    logic                 rst_in;
    logic [WIDTH-1:0]     fifo_data_in;
    logic                 fifo_valid_in;
    logic [OCC_W-1:0]     fifo_occupancy_in;
    logic                 fifo_rd_en_out;
    logic                 flush_in;
    logic [WIDTH-1:0]     m_data_out;
    logic                 m_valid_out;
    logic                 m_ready_in;
    logic [CNT_WIDTH-1:0] words_out;
    logic                 err_out;

    fifo_stream_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BUF_DEPTH(BUF_DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .fifo_data_in      (fifo_data_in),
        .fifo_valid_in     (fifo_valid_in),
        .fifo_occupancy_in (fifo_occupancy_in),
        .fifo_rd_en_out    (fifo_rd_en_out),
        .flush_in          (flush_in),
        .m_data_out        (m_data_out),
        .m_valid_out       (m_valid_out),
        .m_ready_in        (m_ready_in),
        .words_out         (words_out),
        .err_out           (err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec;
    int n_err;
    int cyc;
    int mdl_words;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic inj;
    logic nv;
    logic [WIDTH-1:0] nd;
    logic s_rd, s_valid, s_err;
    logic [WIDTH-1:0] s_data;
    logic [CNT_WIDTH-1:0] s_words;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        fifo_occupancy_in = OCC_W'(fq.size());
    endtask

    // One clock: observe at the falling edge, update the FIFO model's outputs just after the rise
    task automatic step();
        @(negedge clk_in);
        cyc++;
        s_rd = fifo_rd_en_out; s_valid = m_valid_out; s_data = m_data_out;
        s_words = words_out;   s_err = err_out;
        nv = 1'b0;
        if (rst_in) begin
            exp_q.delete();
            mdl_words = 0;
        end else begin
            if (flush_in) begin
                exp_q.delete();
            end else if (m_valid_out && m_ready_in) begin
                if (exp_q.size() == 0) chk("pop_unexpected", 32'(m_data_out), 32'hFFFF_FFFF);
                else chk("pop_data", 32'(m_data_out), 32'(exp_q.pop_front()));
                mdl_words++;
            end
            if (inj) begin
                nv = 1'b1;
                nd = 8'hEE;
            end else if (fifo_rd_en_out) begin
                if (fq.size() == 0) begin
                    chk("rd_on_empty", 32'(1), 32'(0));
                end else begin
                    nd = fq.pop_front();
                    nv = 1'b1;
                    exp_q.push_back(nd);
                end
            end
        end
        @(posedge clk_in);
        #1;
        fifo_valid_in     = nv;
        fifo_data_in      = nv ? nd : '0;
        fifo_occupancy_in = OCC_W'(fq.size());
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (fq.size() != 0 || exp_q.size() != 0); i++) step();
        step();
        chk("drain_done", 32'(fq.size() + exp_q.size()), 32'(0));
    endtask

    task automatic wait_pops(input int base, input int n);
        int i;
        for (i = 0; i < 100 && (mdl_words - base) < n; i++) step();
        chk("wait_pops", 32'(mdl_words - base), 32'(n));
    endtask

    initial begin
        int first, k, n, v, wb, rem, base;
        logic [WIDTH-1:0] nxt;
        logic found;
        n_vec = 0; n_err = 0; cyc = 0; mdl_words = 0; inj = 1'b0;
        rst_in = 1'b1; flush_in = 1'b0; m_ready_in = 1'b0;
        fifo_data_in = '0; fifo_valid_in = 1'b0; fifo_occupancy_in = '0;

        // Reset
        step(); step();
        chk("rst_valid", 32'(s_valid), 32'(0));
        chk("rst_rd", 32'(s_rd), 32'(0));
        rst_in = 1'b0;
        step();
        chk("rst_words", 32'(s_words), 32'(0));
        chk("rst_err", 32'(s_err), 32'(0));
        chk("rst_data", 32'(s_data), 32'(0));
        chk("rst_valid2", 32'(s_valid), 32'(0));

        // Full-rate stream
        m_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        first = -1; k = 0;
        for (int i = 0; i < 40 && k < 8; i++) begin
            step();
            if (s_rd && first < 0) first = cyc;
            if (s_valid) begin
                chk("stream_data", 32'(s_data), 32'(8'h11 + k));
                chk("stream_cycle", 32'(cyc), 32'(first + 2 + k));
                k++;
            end
        end
        chk("stream_count", 32'(k), 32'(8));
        step();
        chk("stream_words", 32'(s_words), 32'(8));
        chk("stream_err", 32'(s_err), 32'(0));

        // Backpressure then random ready
        m_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rd) n++;
            if (i >= 3) chk("bp_hold", 32'(s_data), 32'h21);
        end
        chk("bp_rd_pulses", 32'(n), 32'(2));
        chk("bp_valid", 32'(s_valid), 32'(1));
        for (int i = 0; i < 300 && (fq.size() != 0 || exp_q.size() != 0); i++) begin
            m_ready_in = 1'($urandom_range(0, 1));
            step();
        end
        m_ready_in = 1'b1;
        drain();
        chk("bp_words", 32'(s_words), 32'(16));

        // Empty then single refill
        n = 0; v = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n += int'(s_rd);
            v += int'(s_valid);
        end
        chk("empty_rd", 32'(n), 32'(0));
        chk("empty_valid", 32'(v), 32'(0));
        push(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = s_rd;
        end
        chk("refill_rd", 32'(found), 32'(1));
        step();
        chk("refill_v1", 32'(s_valid), 32'(0));
        step();
        chk("refill_v2", 32'(s_valid), 32'(1));
        chk("refill_data", 32'(s_data), 32'hA5);
        drain();

        // Flush with a word in flight and ready held high
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        wait_pops(mdl_words, 2);
        flush_in = 1'b1;
        step();
        wb = int'(s_words);
        nxt = fq[0];
        chk("flush_rd", 32'(s_rd), 32'(0));
        flush_in = 1'b0;
        step();
        chk("flush_valid", 32'(s_valid), 32'(0));
        chk("flush_words", 32'(s_words), 32'(wb));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = s_valid;
        end
        chk("flush_next", 32'(s_data), 32'(nxt));
        drain();

        // Unexpected FIFO data
        m_ready_in = 1'b0;
        base = mdl_words;
        push(8'h41); push(8'h42);
        for (int i = 0; i < 4; i++) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        step(); step();
        chk("err_set", 32'(s_err), 32'(1));
        chk("err_head", 32'(s_data), 32'h41);
        chk("err_valid", 32'(s_valid), 32'(1));
        m_ready_in = 1'b1;
        drain();
        chk("err_sticky", 32'(s_err), 32'(1));
        chk("err_pops", 32'(mdl_words - base), 32'(2));
        chk("err_idle_valid", 32'(s_valid), 32'(0));

        // Reset mid-stream
        for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
        wait_pops(mdl_words, 3);
        rst_in = 1'b1;
        step();
        chk("mrst_valid", 32'(s_valid), 32'(0));
        chk("mrst_rd", 32'(s_rd), 32'(0));
        rem = fq.size();
        rst_in = 1'b0;
        step();
        chk("mrst_words", 32'(s_words), 32'(0));
        chk("mrst_valid2", 32'(s_valid), 32'(0));
        chk("mrst_err", 32'(s_err), 32'(0));
        drain();
        chk("mrst_tail_words", 32'(s_words), 32'(rem));

        // Random traffic with occasional flushes
        for (int i = 0; i < 600; i++) begin
            if (fq.size() < DEPTH && $urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
            m_ready_in = ($urandom_range(0, 3) != 0);
            flush_in   = ($urandom_range(0, 40) == 0);
            step();
        end
        flush_in = 1'b0;
        m_ready_in = 1'b1;
        drain();
        chk("rand_words", 32'(s_words), 32'(CNT_WIDTH'(mdl_words)));
        chk("rand_err", 32'(s_err), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
